// File: rtl/pcie_cfg_mgmt_responder.sv
// PCIe configuration-management responder.
// Serves cfg_mgmt reads and writes from a per-function DWORD register file and
// answers with a single done pulse, the way the hard IP does.
//
// Handshake: the initiator raises read and/or write together with address,
// function, data and byte enables. It holds the request until it sees
// cfg_mgmt_read_write_done, then drops it. The responder samples the request
// only in the acceptance cycle. It ignores any later change until the request
// has been dropped, so a request still held after done never runs twice.
module pcie_cfg_mgmt_responder #(
    parameter int          FUNC_COUNT   = 4,
    parameter int          REG_DEPTH    = 64,
    parameter int          RESP_LATENCY = 2,
    parameter logic [15:0] VENDOR_ID    = 16'h1234,
    parameter logic [15:0] DEVICE_ID    = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        status_error,
    output logic [1:0]  dbg_state
);

    localparam int AW    = $clog2(REG_DEPTH);
    localparam int TOTAL = FUNC_COUNT * REG_DEPTH;
    localparam int IW    = $clog2(TOTAL);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(RESP_LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    count;
    logic [9:0]    addr_q;
    logic [7:0]    func_q;
    logic [31:0]   data_q;
    logic [3:0]    be_q;
    logic          wr_q;
    logic          both_q;
    logic [31:0]   rd_hold;
    logic [31:0]   regs [TOTAL];

    logic          done;
    logic          dec_ok;
    logic          is_id;
    logic [IW-1:0] idx;
    logic [31:0]   rd_now;

    assign dbg_state = state;

    // Decode the latched request and form the completion outputs.
    always_comb begin
        dec_ok = (int'(func_q) < FUNC_COUNT) && (int'(addr_q) < REG_DEPTH);
        is_id  = dec_ok && (addr_q == 10'd0);
        idx    = IW'(int'(func_q) * REG_DEPTH + int'(addr_q[AW-1:0]));
        done   = (state == S_BUSY) && (count == 4'd0);
        rd_now = 32'd0;
        if (!wr_q && dec_ok) begin
            if (is_id) begin
                rd_now = {DEVICE_ID, VENDOR_ID};
            end else begin
                rd_now = regs[idx];
            end
        end
        cfg_mgmt_read_data       = done ? rd_now : rd_hold;
        cfg_mgmt_read_write_done = done;
        status_error             = done && (both_q || !dec_ok);
    end

    // Transaction FSM: accept, count down the response latency, wait for release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            addr_q  <= 10'd0;
            func_q  <= 8'd0;
            data_q  <= 32'd0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            rd_hold <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_mgmt_read || cfg_mgmt_write) begin
                        addr_q <= cfg_mgmt_addr;
                        func_q <= cfg_mgmt_function_number;
                        data_q <= cfg_mgmt_write_data;
                        be_q   <= cfg_mgmt_byte_enable;
                        wr_q   <= cfg_mgmt_write;
                        both_q <= cfg_mgmt_write && cfg_mgmt_read;
                        count  <= CNT_INIT;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (count == 4'd0) begin
                        state <= S_RELEASE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RELEASE: begin
                    if (!cfg_mgmt_read && !cfg_mgmt_write) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (done) begin
                rd_hold <= rd_now;
            end
        end
    end

    // Register file: cleared on reset, byte-merged write committed in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (done && wr_q && dec_ok && !is_id) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    regs[idx][b*8 +: 8] <= data_q[b*8 +: 8];
                end
            end
        end
    end

endmodule
